// File: rtl/pulse_meter.sv
// Measures each full period of an asynchronous square wave as high/low cycle counts
// and publishes one result per period through a valid/ready handshake.
module pulse_meter #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             signal,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] high_count,
  output logic [WIDTH-1:0] low_count,
  output logic [WIDTH:0]   period,
  output logic             saturated,
  output logic             overrun,
  output logic [7:0]       pulses,
  output logic             rise
);

  typedef enum logic [1:0] {IDLE, ARMED, HIGH, LOW} state_t;

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  state_t                 state_reg, state_next;
  logic [SYNC_STAGES-1:0] sync_reg;
  logic [SYNC_STAGES-1:0] fill_reg;
  logic                   prev_reg;
  logic [WIDTH-1:0]       hcnt_reg, hcnt_next;
  logic [WIDTH-1:0]       lcnt_reg, lcnt_next;
  logic                   sat_reg, sat_next;
  logic                   publish;
  logic                   s, primed, rise_d, fall_d;

  // fill_reg tracks when s holds a real sample rather than the reset zero, so a
  // signal already high at reset release is not mistaken for a low phase.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_reg <= '0;
      fill_reg <= '0;
      prev_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], signal};
      fill_reg <= {fill_reg[SYNC_STAGES-2:0], 1'b1};
      prev_reg <= s;
    end
  end

  assign s      = sync_reg[SYNC_STAGES-1];
  assign primed = fill_reg[SYNC_STAGES-1];
  assign rise_d = s & ~prev_reg;
  assign fall_d = ~s & prev_reg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      hcnt_reg  <= '0;
      lcnt_reg  <= '0;
      sat_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      hcnt_reg  <= hcnt_next;
      lcnt_reg  <= lcnt_next;
      sat_reg   <= sat_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    hcnt_next  = hcnt_reg;
    lcnt_next  = lcnt_reg;
    sat_next   = sat_reg;
    publish    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (primed && !s) state_next = ARMED;
      end
      ARMED: begin
        if (rise_d) begin
          hcnt_next  = CNT_ONE;
          sat_next   = 1'b0;
          state_next = HIGH;
        end
      end
      HIGH: begin
        if (fall_d) begin
          lcnt_next  = CNT_ONE;
          state_next = LOW;
        end else if (hcnt_reg == CNT_MAX) begin
          sat_next = 1'b1;
        end else begin
          hcnt_next = hcnt_reg + CNT_ONE;
        end
      end
      LOW: begin
        if (rise_d) begin
          publish    = 1'b1;
          hcnt_next  = CNT_ONE;
          sat_next   = 1'b0;
          state_next = HIGH;
        end else if (lcnt_reg == CNT_MAX) begin
          sat_next = 1'b1;
        end else begin
          lcnt_next = lcnt_reg + CNT_ONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A publish takes priority over acceptance so a coincident accept keeps valid high.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid      <= 1'b0;
      high_count <= '0;
      low_count  <= '0;
      period     <= '0;
      saturated  <= 1'b0;
      overrun    <= 1'b0;
    end else if (publish) begin
      valid      <= 1'b1;
      high_count <= hcnt_reg;
      low_count  <= lcnt_reg;
      period     <= {1'b0, hcnt_reg} + {1'b0, lcnt_reg};
      saturated  <= sat_reg;
      if (valid && !ready) overrun <= 1'b1;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pulses <= '0;
      rise   <= 1'b0;
    end else begin
      rise <= rise_d && (state_reg != IDLE);
      if (rise_d && (state_reg != IDLE)) pulses <= pulses + 8'd1;
    end
  end

endmodule
